arpas_delay_loader: RTL

Host-side serializer for the ARPAS phased-array timing path. It takes three parallel 13-bit per-element firing delays and shifts them, MSB first, over the `regdat`/`regclk`/`regsla`/`regslb` serial register bus into the three PAS timer channels. It then drives `pdorun` for a programmed number of `sysclk` cycles so the timers fire. It sits between the control/sequencer logic and the PAS timer, and owns every timer-side input except `sysclk`.

---
 rtl/arpas_pkg.sv | 33 +++
 rtl/arpas_ser_phase.sv | 39 +++
 rtl/arpas_delay_loader.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/arpas_pkg.sv
// Shared constants and types for the ARPAS delay loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arpas_pkg;

    // Timer delay word width and number of timer channels.
    localparam int DLY_W = 13;
    localparam int NCH   = 3;

    // Half-period counter and bit-index widths.
    localparam int PH_W  = 4;
    localparam int BIT_W = 4;

    // Channel select codes as driven on {regslb, regsla}.
    localparam logic [1:0] SEL_A    = 2'b00;
    localparam logic [1:0] SEL_B    = 2'b01;
    localparam logic [1:0] SEL_C    = 2'b10;
    localparam logic [1:0] SEL_IDLE = 2'b11;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHIFT_LO = 3'd1,
        SHIFT_HI = 3'd2,
        GAP      = 3'd3,
        RUN      = 3'd4
    } ldr_state_t;

    // States whose length is one regclk half-period.
    function automatic logic is_timed(input ldr_state_t s);
        return (s == SHIFT_LO) || (s == SHIFT_HI) || (s == GAP);
    endfunction

endpackage

// File: rtl/arpas_ser_phase.sv
// Half-period timer: strobes phase_end on the last of CLKDIV cycles while en is high.
// Latency: phase_end is combinational from the registered count; first strobe CLKDIV cycles after en rises.
// Backpressure: none; en low holds the counter reloaded so each timed state starts a full period.
module arpas_ser_phase
    import arpas_pkg::*;
#(
    parameter int CLKDIV = 4
) (
    input  logic sysclk,
    input  logic rstall,
    input  logic en,
    output logic phase_end
);

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLKDIV - 1);

    logic [PH_W-1:0] cnt_q;
    logic [PH_W-1:0] cnt_d;

    // Count down to zero, then reload; idle time keeps the counter primed.
    always_comb begin
        cnt_d = cnt_q - PH_W'(1);
        if (!en || (cnt_q == '0)) begin
            cnt_d = PH_LAST;
        end
    end

    assign phase_end = en && (cnt_q == '0);

    // Half-period counter register.
    always_ff @(posedge sysclk or posedge rstall) begin
        if (rstall) begin
            cnt_q <= PH_LAST;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/arpas_delay_loader.sv
// Serialises three 13-bit delay words MSB-first into the PAS timer channels, then pulses pdorun for RUN_LEN cycles.
// Latency: busy from cycle 1 after start; load takes 81*CLKDIV cycles, run RUN_LEN cycles, done one cycle later.
// Backpressure: start is ignored while busy (no queueing); abort cancels any active sequence in one cycle.
module arpas_delay_loader
    import arpas_pkg::*;
#(
    parameter int CLKDIV  = 4,
    parameter int RUN_LEN = 8191
) (
    input  logic             sysclk,
    input  logic             rstall,
    input  logic             start,
    input  logic             abort,
    input  logic [DLY_W-1:0] dly_a,
    input  logic [DLY_W-1:0] dly_b,
    input  logic [DLY_W-1:0] dly_c,
    output logic             busy,
    output logic             done,
    output logic             regdat,
    output logic             regclk,
    output logic             regsla,
    output logic             regslb,
    output logic             pdorun
);

    localparam logic [BIT_W-1:0] BIT_MSB  = BIT_W'(DLY_W - 1);
    localparam logic [DLY_W-1:0] RUN_LAST = (RUN_LEN > 0) ? DLY_W'(RUN_LEN - 1) : '0;

    ldr_state_t                  state_q, state_d;
    logic [1:0]                  ch_q, ch_d;
    logic [BIT_W-1:0]            bit_idx_q, bit_idx_d;
    logic [DLY_W-1:0]            run_cnt_q, run_cnt_d;
    logic [NCH-1:0][DLY_W-1:0]   shadow_q, shadow_d;
    logic                        regclk_q, regclk_d;
    logic                        regdat_q, regdat_d;
    logic [1:0]                  sel_q, sel_d;
    logic                        pdorun_q, pdorun_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        phase_end;

    arpas_ser_phase #(
        .CLKDIV (CLKDIV)
    ) u_phase (
        .sysclk    (sysclk),
        .rstall    (rstall),
        .en        (is_timed(state_q)),
        .phase_end (phase_end)
    );

    // Sequencer next state: shift bits per channel, gap between channels, then run.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        bit_idx_d = bit_idx_q;
        run_cnt_d = run_cnt_q;
        shadow_d  = shadow_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    shadow_d  = {dly_c, dly_b, dly_a};
                    ch_d      = SEL_A;
                    bit_idx_d = BIT_MSB;
                    state_d   = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (phase_end) begin
                    state_d = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (phase_end) begin
                    if (bit_idx_q != '0) begin
                        bit_idx_d = bit_idx_q - BIT_W'(1);
                        state_d   = SHIFT_LO;
                    end else begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (phase_end) begin
                    if (ch_q != SEL_C) begin
                        ch_d      = ch_q + 2'd1;
                        bit_idx_d = BIT_MSB;
                        state_d   = SHIFT_LO;
                    end else if (RUN_LEN > 0) begin
                        run_cnt_d = RUN_LAST;
                        state_d   = RUN;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (run_cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    run_cnt_d = run_cnt_q - DLY_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Cancel wins over everything; the shadow words are simply abandoned.
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end
    end

    // Registered bus outputs derived from the state being entered, so they change on entry cycles only.
    always_comb begin
        regclk_d = (state_d == SHIFT_HI);
        pdorun_d = (state_d == RUN);
        busy_d   = (state_d != IDLE);
        regdat_d = 1'b0;
        sel_d    = SEL_IDLE;
        case (state_d)
            SHIFT_LO: begin
                regdat_d = shadow_d[ch_d][bit_idx_d];
                sel_d    = ch_d;
            end
            SHIFT_HI: begin
                regdat_d = regdat_q;
                sel_d    = sel_q;
            end
            default: begin
                regdat_d = 1'b0;
                sel_d    = SEL_IDLE;
            end
        endcase
    end

    // Sequencer state, shadow words, counters and registered outputs.
    always_ff @(posedge sysclk or posedge rstall) begin
        if (rstall) begin
            state_q   <= IDLE;
            ch_q      <= SEL_A;
            bit_idx_q <= '0;
            run_cnt_q <= '0;
            shadow_q  <= '0;
            regclk_q  <= 1'b0;
            regdat_q  <= 1'b0;
            sel_q     <= SEL_IDLE;
            pdorun_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            bit_idx_q <= bit_idx_d;
            run_cnt_q <= run_cnt_d;
            shadow_q  <= shadow_d;
            regclk_q  <= regclk_d;
            regdat_q  <= regdat_d;
            sel_q     <= sel_d;
            pdorun_q  <= pdorun_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign regdat = regdat_q;
    assign regclk = regclk_q;
    assign regsla = sel_q[0];
    assign regslb = sel_q[1];
    assign pdorun = pdorun_q;

endmodule
